// File: rtl/fm_pattern_gen.sv
// Fast-monitoring test-pattern source: emits DEPTH-word bursts every PERIOD cycles on a
// valid-tagged monitor bus with backpressure, from a fixed table, a ramp or a 32-bit LFSR.
module fm_pattern_gen #(
    parameter int                               DATA_WIDTH = 32,
    parameter int                               DEPTH      = 3,
    parameter int                               PERIOD     = 64,
    parameter logic [DEPTH-1:0][DATA_WIDTH-1:0] PATTERN    = {32'h0BEECAFE, 32'h000FEED5, 32'h00C0FFEE},
    parameter logic [31:0]                      SEED       = 32'h00C0FFEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  mon_ready,
    output logic [DATA_WIDTH:0]   mon_data,
    output logic [15:0]           frame_cnt,
    output logic                  overrun
);
    localparam int          IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          PCW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [PCW-1:0]         pcnt_q, pcnt_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [1:0]             mode_q, mode_d;
    logic [31:0]            ramp_q, ramp_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]  payload_q, payload_d;
    logic [15:0]            frame_q, frame_d;
    logic                   overrun_q, overrun_d;
    logic                   valid, accept, last, start;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [1:0] m, input logic [IDXW-1:0] i,
                                                       input logic [31:0] ramp, input logic [31:0] lfsr);
        case (m)
            2'd1:    return DATA_WIDTH'(ramp);
            2'd2:    return DATA_WIDTH'(lfsr);
            default: return PATTERN[i];
        endcase
    endfunction

    assign valid  = (state_q == S_BURST);
    // Dropping enable aborts the word on the bus, so it never counts as accepted.
    assign accept = valid && mon_ready && enable;
    assign last   = (idx_q == IDXW'(DEPTH - 1));
    assign start  = (state_q == S_IDLE) && enable && (pcnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            idx_q     <= '0;
            mode_q    <= 2'd0;
            ramp_q    <= 32'h0;
            lfsr_q    <= SEED;
            payload_q <= '0;
            frame_q   <= 16'h0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            ramp_q    <= ramp_d;
            lfsr_q    <= lfsr_d;
            payload_q <= payload_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BURST;
            S_BURST: if (!enable || (accept && last)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pcnt_d    = '0;
        idx_d     = idx_q;
        mode_d    = mode_q;
        ramp_d    = ramp_q;
        lfsr_d    = lfsr_q;
        payload_d = payload_q;
        frame_d   = frame_q;
        // A period boundary seen while still busy means that burst start is lost.
        overrun_d = overrun_q | (valid && enable && (pcnt_q == '0));

        if (enable && (pcnt_q != PCW'(PERIOD - 1))) pcnt_d = pcnt_q + 1'b1;

        if (start) begin
            idx_d     = '0;
            mode_d    = mode;
            payload_d = word_sel(mode, '0, ramp_q, lfsr_q);
        end else if (valid) begin
            if (!enable) begin
                payload_d = '0;
            end else if (accept) begin
                if (mode_q == 2'd1) ramp_d = ramp_q + 32'd1;
                if (mode_q == 2'd2) lfsr_d = lfsr_step(lfsr_q);
                if (last) begin
                    payload_d = '0;
                    frame_d   = frame_q + 16'd1;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    payload_d = word_sel(mode_q, idx_d, ramp_d, lfsr_d);
                end
            end
        end
    end

    assign mon_data  = {valid, payload_q};
    assign frame_cnt = frame_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_fm_pattern_gen.sv
// Scoreboard bench for fm_pattern_gen: a burst-level reference model queues expected
// bus status and words; an independent monitor checks the DUT each cycle.
module tb_fm_pattern_gen;
    localparam int DW     = 32;
    localparam int DEPTH  = 3;
    localparam int PERIOD = 64;
    localparam logic [31:0] SEED = 32'h00C0FFEE;

    logic          clk = 1'b0;
    logic          rst, enable, mon_ready;
    logic [1:0]    mode;
    logic [DW:0]   mon_data;
    logic [15:0]   frame_cnt;
    logic          overrun;

    fm_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .mon_ready (mon_ready),
        .mon_data  (mon_data),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [15:0] frames;
        logic        over;
    } status_t;

    status_t     st_q[$];
    logic [31:0] word_q[$];
    int          checks = 0;
    int          passes = 0;

    // reference model state
    bit          m_busy;
    int          m_k;
    int          m_phase;
    logic [1:0]  m_mode;
    int unsigned m_ramp;
    logic [31:0] m_lfsr;
    logic [15:0] m_frames;
    bit          m_over;
    logic [31:0] tbl [DEPTH] = '{32'h00C0FFEE, 32'h000FEED5, 32'h0BEECAFE};

    int stall;
    bit rdy_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_word();
        case (m_mode)
            2'd1:    return m_ramp;
            2'd2:    return m_lfsr;
            default: return tbl[m_k];
        endcase
    endfunction

    // Expected effect of one clock edge given the inputs applied before it.
    task automatic model_edge(input bit r, input bit en, input logic [1:0] md, input bit rdy);
        status_t s;
        if (r) begin
            m_busy = 0; m_k = 0; m_phase = 0; m_mode = 2'd0;
            m_ramp = 0; m_lfsr = SEED; m_frames = 16'h0; m_over = 0;
        end else begin
            if (m_busy) begin
                if (!en) begin
                    m_busy = 0;
                end else begin
                    if (m_phase == 0) m_over = 1;
                    if (rdy) begin
                        if (m_mode == 2'd1) m_ramp = m_ramp + 1;
                        else if (m_mode == 2'd2) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
                        m_k = m_k + 1;
                        if (m_k == DEPTH) begin
                            m_busy = 0;
                            m_frames = m_frames + 16'd1;
                        end
                    end
                end
            end else if (en && m_phase == 0) begin
                m_busy = 1; m_k = 0; m_mode = md;
            end
            m_phase = en ? (m_phase + 1) % PERIOD : 0;
        end
        if (m_busy) word_q.push_back(ref_word());
        s.vld = m_busy; s.frames = m_frames; s.over = m_over;
        st_q.push_back(s);
    endtask

    task automatic step(input bit r, input bit en, input logic [1:0] md, input bit rdy);
        @(negedge clk);
        rst = r; enable = en; mode = md; mon_ready = rdy;
        model_edge(r, en, md, rdy);
    endtask

    // monitor
    initial begin
        status_t e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("valid", 64'(mon_data[DW]), 64'(e.vld));
                chk("frame_cnt", 64'(frame_cnt), 64'(e.frames));
                chk("overrun", 64'(overrun), 64'(e.over));
                if (mon_data[DW]) begin
                    if (word_q.size() == 0) chk("unexpected_word", 64'(mon_data[DW-1:0]), 64'hDEAD_0000_0000);
                    else chk("payload", 64'(mon_data[DW-1:0]), 64'(word_q.pop_front()));
                end else begin
                    chk("idle_payload", 64'(mon_data[DW-1:0]), 64'h0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; mon_ready = 1'b0;
        repeat (3) step(1, 0, 2'd0, 0);

        // table mode, free-flowing sink
        repeat (140) step(0, 1, 2'd0, 1);

        // stall five cycles on word 1
        stall = 0;
        repeat (130) begin
            rdy_v = 1;
            if (m_busy && m_k == 1 && stall < 5) begin rdy_v = 0; stall++; end
            step(0, 1, 2'd0, rdy_v);
        end

        // long stall across a period boundary -> overrun
        repeat (2) step(1, 0, 2'd0, 0);
        step(0, 1, 2'd0, 1);
        repeat (70) step(0, 1, 2'd0, 0);
        repeat (140) step(0, 1, 2'd0, 1);

        // ramp over two periods
        repeat (2) step(1, 0, 2'd0, 0);
        repeat (130) step(0, 1, 2'd1, 1);

        // LFSR, then with random backpressure
        repeat (2) step(1, 0, 2'd0, 0);
        repeat (70) step(0, 1, 2'd2, 1);
        repeat (200) step(0, 1, 2'd2, $urandom_range(0, 2) != 0);

        // reset on the second word of a burst
        repeat (2) step(1, 0, 2'd0, 0);
        for (int i = 0; i < 200 && !(m_busy && m_k == 1); i++) step(0, 1, 2'd0, 1);
        step(1, 1, 2'd0, 1);
        step(1, 0, 2'd0, 0);
        repeat (70) step(0, 1, 2'd0, 1);

        // enable drop mid-burst
        for (int i = 0; i < 200 && !(m_busy && m_k == 1); i++) step(0, 1, 2'd1, 1);
        repeat (3) step(0, 0, 2'd1, 1);
        repeat (140) step(0, 1, 2'd1, 1);

        // random modes, backpressure and occasional enable drops
        repeat (2) step(1, 0, 2'd0, 0);
        repeat (600) step(0, $urandom_range(0, 49) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);

        repeat (3) @(negedge clk);
        chk("status_drained", 64'(st_q.size()), 64'h0);
        chk("words_drained", 64'(word_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
